// File: rtl/dm_responder.sv
`default_nettype none
// ============================================================================
//  Module   : dm_responder
//  Brief    : MEM-stage data responder: word RAM with byte-lane stores plus an
//             MMIO window (cycle counter, LED register, sticky fault flags).
//  Revision : 1.0  initial release
// ============================================================================
module dm_responder #(
    parameter int          DEPTH_WORDS = 128,
    parameter logic [31:0] MMIO_BASE   = 32'h0000_F000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_w,
    input  logic [31:0] addr_in,
    input  logic [31:0] wdata_in,
    input  logic [2:0]  DMType,
    output logic [31:0] rdata_out,
    output logic [15:0] led_out,
    output logic        err_align,
    output logic        err_range
);

    localparam int          c_IDX_W     = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [31:0] c_RAM_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [29:0] c_CNT_WORD  = MMIO_BASE[31:2];
    localparam logic [29:0] c_LED_WORD  = MMIO_BASE[31:2] + 30'd1;
    localparam logic [29:0] c_FLG_WORD  = MMIO_BASE[31:2] + 30'd2;

    logic [31:0] r_mem [DEPTH_WORDS];
    logic [31:0] r_cnt;
    logic [15:0] r_led;
    logic        r_err_align;
    logic        r_err_range;

    logic               w_is_half, w_is_byte, w_is_word, w_signed, w_aligned;
    logic               w_in_ram, w_in_cnt, w_in_led, w_in_flg, w_in_range;
    logic               w_hit, w_ram_we;
    logic [c_IDX_W-1:0] w_idx;
    logic [3:0]         w_be;
    logic [31:0]        w_wrep, w_word, w_shifted;

    // Reserved DMType codes 101-111 fall through to word behaviour.
    assign w_is_half = (DMType == 3'b001) || (DMType == 3'b010);
    assign w_is_byte = (DMType == 3'b011) || (DMType == 3'b100);
    assign w_is_word = !(w_is_half || w_is_byte);
    assign w_signed  = (DMType == 3'b001) || (DMType == 3'b011);
    assign w_aligned = w_is_byte || (w_is_half && !addr_in[0])
                     || (w_is_word && (addr_in[1:0] == 2'b00));

    assign w_in_ram   = addr_in < c_RAM_BYTES;
    assign w_in_cnt   = addr_in[31:2] == c_CNT_WORD;
    assign w_in_led   = addr_in[31:2] == c_LED_WORD;
    assign w_in_flg   = addr_in[31:2] == c_FLG_WORD;
    assign w_in_range = w_in_ram || w_in_cnt || w_in_led || w_in_flg;

    assign w_idx    = addr_in[c_IDX_W+1:2];
    assign w_hit    = mem_w && w_aligned;
    assign w_ram_we = w_hit && w_in_ram && !reset;

    always_comb begin
        w_be   = 4'b1111;
        w_wrep = wdata_in;
        if (w_is_half) begin
            w_be   = addr_in[1] ? 4'b1100 : 4'b0011;
            w_wrep = {2{wdata_in[15:0]}};
        end else if (w_is_byte) begin
            w_be   = 4'b0001 << addr_in[1:0];
            w_wrep = {4{wdata_in[7:0]}};
        end
    end

    // RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_ram_we) begin
            for (int l = 0; l < 4; l++) begin
                if (w_be[l]) r_mem[w_idx][8*l +: 8] <= w_wrep[8*l +: 8];
            end
        end
    end

    always_comb begin
        w_word = 32'h0;
        if (w_in_ram)      w_word = r_mem[w_idx];
        else if (w_in_cnt) w_word = r_cnt;
        else if (w_in_led) w_word = {16'h0, r_led};
        else if (w_in_flg) w_word = {30'h0, r_err_range, r_err_align};
    end

    assign w_shifted = w_word >> {addr_in[1:0], 3'b000};

    always_comb begin
        rdata_out = w_shifted;
        if (!w_aligned || !w_in_range)
            rdata_out = 32'h0;
        else if (w_is_half)
            rdata_out = {{16{w_signed & w_shifted[15]}}, w_shifted[15:0]};
        else if (w_is_byte)
            rdata_out = {{24{w_signed & w_shifted[7]}}, w_shifted[7:0]};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt       <= 32'h0;
            r_led       <= 16'h0;
            r_err_align <= 1'b0;
            r_err_range <= 1'b0;
        end else begin
            if (w_hit && w_in_cnt && w_is_word) r_cnt <= wdata_in;
            else                                r_cnt <= r_cnt + 32'd1;

            // Byte lanes 2/3 of the LED word have no backing bits.
            if (w_hit && w_in_led) begin
                if (!w_is_byte)                  r_led        <= wdata_in[15:0];
                else if (addr_in[1:0] == 2'b00)  r_led[7:0]   <= wdata_in[7:0];
                else if (addr_in[1:0] == 2'b01)  r_led[15:8]  <= wdata_in[7:0];
            end

            if (w_hit && w_in_flg && w_is_word) begin
                r_err_align <= 1'b0;
                r_err_range <= 1'b0;
            end else begin
                if (mem_w && !w_aligned)  r_err_align <= 1'b1;
                if (mem_w && !w_in_range) r_err_range <= 1'b1;
            end
        end
    end

    assign led_out   = r_led;
    assign err_align = r_err_align;
    assign err_range = r_err_range;

endmodule
`default_nettype wire

// File: tb/tb_dm_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dm_responder
//  Brief    : Scoreboard bench for dm_responder against a byte-addressed model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_dm_responder;

    localparam int          c_DEPTH = 128;
    localparam int          c_BYTES = 4 * c_DEPTH;
    localparam logic [31:0] c_BASE  = 32'h0000_F000;
    localparam logic [31:0] c_CNT   = c_BASE;
    localparam logic [31:0] c_LED   = c_BASE + 32'd4;
    localparam logic [31:0] c_FLG   = c_BASE + 32'd8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_w = 1'b0;
    logic [31:0] addr_in = 32'h0;
    logic [31:0] wdata_in = 32'h0;
    logic [2:0]  DMType = 3'b000;
    logic [31:0] rdata_out;
    logic [15:0] led_out;
    logic        err_align, err_range;

    dm_responder #(.DEPTH_WORDS(c_DEPTH), .MMIO_BASE(c_BASE)) u_dut (
        .clk(clk), .reset(reset), .mem_w(mem_w), .addr_in(addr_in),
        .wdata_in(wdata_in), .DMType(DMType), .rdata_out(rdata_out),
        .led_out(led_out), .err_align(err_align), .err_range(err_range)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic [15:0] led;
        logic        ea;
        logic        er;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   failures = 0;

    logic [7:0]  mem_b [c_BYTES];
    logic [31:0] m_cnt;
    logic [15:0] m_led;
    logic        m_ea, m_er;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%08h expected=%08h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int sz(input logic [2:0] t);
        if (t == 3'd1 || t == 3'd2) return 2;
        if (t == 3'd3 || t == 3'd4) return 1;
        return 4;
    endfunction

    // 0 RAM, 1 counter, 2 LED, 3 flags, 4 unmapped
    function automatic int region(input logic [31:0] a);
        if (a < 32'(c_BYTES))      return 0;
        if ((a >> 2) == (c_CNT >> 2)) return 1;
        if ((a >> 2) == (c_LED >> 2)) return 2;
        if ((a >> 2) == (c_FLG >> 2)) return 3;
        return 4;
    endfunction

    function automatic logic [31:0] model_read(input logic [31:0] a, input logic [2:0] t);
        int          s;
        int          rg;
        logic [63:0] v;
        logic [31:0] w;
        s  = sz(t);
        rg = region(a);
        v  = 64'h0;
        if ((a % s) != 0 || rg == 4) return 32'h0;
        if (rg == 0) begin
            for (int i = 0; i < s; i++) v[8*i +: 8] = mem_b[int'(a) + i];
        end else begin
            w = (rg == 1) ? m_cnt : (rg == 2) ? {16'h0, m_led} : {30'h0, m_er, m_ea};
            v = 64'(w) >> (8 * (a % 4));
            if (s < 4) v = v & ((64'd1 << (8 * s)) - 64'd1);
        end
        if (t == 3'd1 && v[15]) v[31:16] = 16'hFFFF;
        if (t == 3'd3 && v[7])  v[31:8]  = 24'hFF_FFFF;
        return v[31:0];
    endfunction

    // State after the next rising edge.
    function automatic void model_edge(input logic w, input logic [31:0] a,
                                       input logic [31:0] d, input logic [2:0] t);
        int          s;
        int          rg;
        logic [31:0] cnt_n;
        s     = sz(t);
        rg    = region(a);
        cnt_n = m_cnt + 32'd1;
        if (w) begin
            if ((a % s) != 0) m_ea = 1'b1;
            if (rg == 4)      m_er = 1'b1;
            if ((a % s) == 0) begin
                case (rg)
                    0: for (int i = 0; i < s; i++) mem_b[int'(a) + i] = d[8*i +: 8];
                    1: if (s == 4) cnt_n = d;
                    2: begin
                        if (s > 1)           m_led       = d[15:0];
                        else if (a % 4 == 0) m_led[7:0]  = d[7:0];
                        else if (a % 4 == 1) m_led[15:8] = d[7:0];
                    end
                    3: if (s == 4) begin m_ea = 1'b0; m_er = 1'b0; end
                    default: ;
                endcase
            end
        end
        m_cnt = cnt_n;
    endfunction

    function automatic void model_reset();
        m_cnt = 32'h0;
        m_led = 16'h0;
        m_ea  = 1'b0;
        m_er  = 1'b0;
    endfunction

    task automatic drive(input logic w, input logic [31:0] a, input logic [31:0] d,
                         input logic [2:0] t, input bit en);
        exp_t e;
        mem_w = w; addr_in = a; wdata_in = d; DMType = t;
        if (en) begin
            e.rdata = model_read(a, t);
            e.led   = m_led;
            e.ea    = m_ea;
            e.er    = m_er;
            sb.push_back(e);
        end
        model_edge(w, a, d, t);
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_cycle();
        int unsigned r;
        logic [31:0] a;
        r = $urandom_range(0, 99);
        if (r < 60)      a = $urandom_range(0, c_BYTES - 1);
        else if (r < 68) a = c_CNT + $urandom_range(0, 3);
        else if (r < 82) a = c_LED + $urandom_range(0, 3);
        else if (r < 88) a = c_FLG + $urandom_range(0, 3);
        else if (r < 94) a = $urandom_range(c_BYTES, 32'h0000_EFFF);
        else             a = $urandom() | 32'h0001_0000;
        drive(1'($urandom_range(0, 1)), a, $urandom(), 3'($urandom_range(0, 7)), 1'b1);
        step();
    endtask

    initial begin : p_monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("sb_rdata",     rdata_out,        e.rdata);
                chk("sb_led",       32'(led_out),     32'(e.led));
                chk("sb_err_align", 32'(err_align),   32'(e.ea));
                chk("sb_err_range", 32'(err_range),   32'(e.er));
            end
        end
    end

    initial begin : p_timeout
        #2_000_000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin : p_stim
        model_reset();
        #3;
        chk("rst_led",       32'(led_out),   32'h0);
        chk("rst_err_align", 32'(err_align), 32'h0);
        chk("rst_err_range", 32'(err_range), 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Fill the RAM so every later read has a known value.
        for (int w = 0; w < c_DEPTH; w++) begin
            drive(1'b1, 32'(4 * w), $urandom(), 3'd0, 1'b0);
            step();
        end

        drive(1'b1, 32'h10, 32'hDEAD_BEEF, 3'd0, 1'b1); step();
        drive(1'b0, 32'h10, 32'h0, 3'd0, 1'b1);
        chk("word_rd", rdata_out, 32'hDEAD_BEEF); step();

        drive(1'b1, 32'h13, 32'h80, 3'd3, 1'b1); step();
        drive(1'b0, 32'h13, 32'h0, 3'd3, 1'b1);
        chk("byte_sext", rdata_out, 32'hFFFF_FF80); step();
        drive(1'b0, 32'h13, 32'h0, 3'd4, 1'b1);
        chk("byte_zext", rdata_out, 32'h0000_0080); step();
        drive(1'b0, 32'h10, 32'h0, 3'd0, 1'b1);
        chk("byte_merge", rdata_out, 32'h80AD_BEEF); step();

        drive(1'b1, 32'h16, 32'h1234, 3'd1, 1'b1); step();
        drive(1'b0, 32'h16, 32'h0, 3'd2, 1'b1);
        chk("half_zext", rdata_out, 32'h0000_1234); step();
        drive(1'b1, 32'h11, 32'hFFFF, 3'd1, 1'b1);
        chk("misalign_rd", rdata_out, 32'h0); step();
        drive(1'b0, 32'h10, 32'h0, 3'd0, 1'b1);
        chk("misalign_nowr", rdata_out, 32'h80AD_BEEF);
        chk("misalign_flag", 32'(err_align), 32'h1); step();

        drive(1'b1, c_CNT, 32'hFFFF_FFFE, 3'd0, 1'b1); step();
        repeat (3) begin drive(1'b0, c_CNT, 32'h0, 3'd0, 1'b1); step(); end
        drive(1'b0, c_CNT, 32'h0, 3'd0, 1'b1);
        chk("cnt_wrap", rdata_out, 32'h0000_0001); step();

        drive(1'b1, 32'h0000_8000, 32'h5555_5555, 3'd0, 1'b1);
        chk("oor_rd", rdata_out, 32'h0); step();
        drive(1'b0, c_FLG, 32'h0, 3'd0, 1'b1);
        chk("oor_flag", 32'(err_range), 32'h1); step();
        drive(1'b1, c_FLG, 32'h0, 3'd0, 1'b1); step();
        drive(1'b0, c_FLG, 32'h0, 3'd0, 1'b1);
        chk("flg_clear", {30'h0, err_range, err_align}, 32'h0); step();

        drive(1'b1, c_LED, 32'hABCD_1234, 3'd0, 1'b1); step();
        drive(1'b0, c_LED, 32'h0, 3'd0, 1'b1);
        chk("led_word", 32'(led_out), 32'h1234); step();

        repeat (2500) rand_cycle();

        drive(1'b1, c_LED, 32'h0000_5A5A, 3'd0, 1'b1); step();
        mem_w = 1'b0; addr_in = c_CNT; DMType = 3'd0;
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        chk("async_led", 32'(led_out), 32'h0);
        chk("async_cnt", rdata_out,    32'h0);
        @(posedge clk);
        #1;
        chk("hold_cnt", rdata_out, 32'h0);
        reset = 1'b0;

        repeat (300) rand_cycle();

        @(negedge clk);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'h0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
